// File: rtl/regs_param_iss.sv
// Parametrised register file for the ISS: registered read ports with write bypass,
// a pending-write scoreboard, and the flattened full register view.
module regs_param_iss #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     CtlToRegs_port_sync,
   input  logic [AW-1:0]            CtlToRegs_dst,
   input  logic [XLEN-1:0]          CtlToRegs_dstdata,
   input  logic                     CtlToRegs_reserve_sync,
   input  logic [AW-1:0]            CtlToRegs_reserve_dst,
   input  logic [NUM_RD-1:0]        rd_req,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*XLEN-1:0]   rd_data,
   output logic [NUM_RD-1:0]        rd_valid,
   output logic [NUM_REGS-1:0]      busy,
   output logic [NUM_REGS*XLEN-1:0] RegsToCtl_port
);

   logic [XLEN-1:0]     regs_q    [NUM_REGS];
   logic [XLEN-1:0]     regs_d    [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [XLEN-1:0]     rd_data_q [NUM_RD];
   logic [XLEN-1:0]     rd_data_d [NUM_RD];
   logic [NUM_RD-1:0]   rd_valid_q, rd_valid_d;

   logic wr_zero, rsv_zero;
   assign wr_zero  = (ZERO_REG != 0) && (CtlToRegs_dst == '0);
   assign rsv_zero = (ZERO_REG != 0) && (CtlToRegs_reserve_dst == '0);

   always_comb begin
      regs_d = regs_q;
      if (CtlToRegs_port_sync && !wr_zero)
         regs_d[CtlToRegs_dst] = CtlToRegs_dstdata;
   end

   // Reserve is applied after the write clear so a same-register collision stays busy.
   always_comb begin
      busy_d = busy_q;
      if (CtlToRegs_port_sync)
         busy_d[CtlToRegs_dst] = 1'b0;
      if (CtlToRegs_reserve_sync && !rsv_zero)
         busy_d[CtlToRegs_reserve_dst] = 1'b1;
   end

   always_comb begin
      rd_valid_d = rd_req;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_data_d[i] = rd_data_q[i];
         if (rd_req[i]) begin
            if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0))
               rd_data_d[i] = '0;
            else if (CtlToRegs_port_sync && (CtlToRegs_dst == rd_addr[i*AW +: AW]))
               rd_data_d[i] = CtlToRegs_dstdata;
            else
               rd_data_d[i] = regs_q[rd_addr[i*AW +: AW]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++)
            regs_q[r] <= '0;
         for (int i = 0; i < NUM_RD; i++)
            rd_data_q[i] <= '0;
         busy_q     <= '0;
         rd_valid_q <= '0;
      end else begin
         regs_q     <= regs_d;
         rd_data_q  <= rd_data_d;
         busy_q     <= busy_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_view
      assign RegsToCtl_port[g*XLEN +: XLEN] = regs_q[g];
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      assign rd_data[p*XLEN +: XLEN] = rd_data_q[p];
   end

   assign rd_valid = rd_valid_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_regs_param_iss.sv
// Directed bench for regs_param_iss: default configuration plus a
// 16-bit / 8-register / 3-port instance without a hardwired zero register.
module tb_regs_param_iss;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // default instance: XLEN=32, NUM_REGS=32, NUM_RD=2, ZERO_REG=1
   logic         a_wr, a_rsv;
   logic [4:0]   a_dst, a_rdst;
   logic [31:0]  a_wdata;
   logic [1:0]   a_req;
   logic [9:0]   a_addr;
   logic [63:0]  a_rdata;
   logic [1:0]   a_rvld;
   logic [31:0]  a_busy;
   logic [1023:0] a_view;

   // second instance: XLEN=16, NUM_REGS=8, NUM_RD=3, ZERO_REG=0
   logic         b_wr, b_rsv;
   logic [2:0]   b_dst, b_rdst;
   logic [15:0]  b_wdata;
   logic [2:0]   b_req;
   logic [8:0]   b_addr;
   logic [47:0]  b_rdata;
   logic [2:0]   b_rvld;
   logic [7:0]   b_busy;
   logic [127:0] b_view;

   regs_param_iss dut_a (
      .clk(clk), .rst(rst),
      .CtlToRegs_port_sync(a_wr), .CtlToRegs_dst(a_dst), .CtlToRegs_dstdata(a_wdata),
      .CtlToRegs_reserve_sync(a_rsv), .CtlToRegs_reserve_dst(a_rdst),
      .rd_req(a_req), .rd_addr(a_addr), .rd_data(a_rdata), .rd_valid(a_rvld),
      .busy(a_busy), .RegsToCtl_port(a_view)
   );

   regs_param_iss #(.XLEN(16), .NUM_REGS(8), .NUM_RD(3), .ZERO_REG(0)) dut_b (
      .clk(clk), .rst(rst),
      .CtlToRegs_port_sync(b_wr), .CtlToRegs_dst(b_dst), .CtlToRegs_dstdata(b_wdata),
      .CtlToRegs_reserve_sync(b_rsv), .CtlToRegs_reserve_dst(b_rdst),
      .rd_req(b_req), .rd_addr(b_addr), .rd_data(b_rdata), .rd_valid(b_rvld),
      .busy(b_busy), .RegsToCtl_port(b_view)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      a_wr = 0; a_rsv = 0; a_req = '0;
      b_wr = 0; b_rsv = 0; b_req = '0;
   endtask

   initial begin
      #1;
      // reset with arbitrary activity on every input
      rst = 1;
      a_wr = 1; a_dst = 5'd5; a_wdata = 32'h1234_5678; a_rsv = 1; a_rdst = 5'd4;
      a_req = 2'b11; a_addr = {5'd5, 5'd5};
      b_wr = 1; b_dst = 3'd2; b_wdata = 16'hBEEF; b_rsv = 1; b_rdst = 3'd1;
      b_req = 3'b111; b_addr = {3'd2, 3'd2, 3'd2};
      tick; tick;
      check("rst_view_a",  {63'd0, |a_view}, 64'd0);
      check("rst_busy_a",  {32'd0, a_busy}, 64'd0);
      check("rst_valid_a", {62'd0, a_rvld}, 64'd0);
      check("rst_rdata_a", a_rdata, 64'd0);
      check("rst_view_b",  {63'd0, |b_view}, 64'd0);
      check("rst_busy_b",  {56'd0, b_busy}, 64'd0);

      // write reg5 then read it
      rst = 0; idle;
      a_wr = 1; a_dst = 5'd5; a_wdata = 32'hDEAD_BEEF;
      tick;
      check("view_reg5", {32'd0, a_view[5*32 +: 32]}, 64'hDEAD_BEEF);
      idle; a_req = 2'b01; a_addr = {5'd0, 5'd5};
      tick;
      check("rd_valid_reg5", {62'd0, a_rvld}, 64'd1);
      check("rd_data_reg5",  {32'd0, a_rdata[31:0]}, 64'hDEAD_BEEF);
      // held request keeps valid high
      tick;
      check("rd_valid_b2b", {62'd0, a_rvld}, 64'd1);

      // same-cycle write plus two reads of reg7
      idle;
      a_wr = 1; a_dst = 5'd7; a_wdata = 32'h1234_5678;
      a_req = 2'b11; a_addr = {5'd7, 5'd7};
      tick;
      check("bypass_valid", {62'd0, a_rvld}, 64'd3);
      check("bypass_data",  a_rdata, 64'h1234_5678_1234_5678);
      check("view_reg7",    {32'd0, a_view[7*32 +: 32]}, 64'h1234_5678);

      // dropping the request clears valid but holds data
      idle;
      tick;
      check("idle_valid", {62'd0, a_rvld}, 64'd0);
      check("idle_hold",  a_rdata, 64'h1234_5678_1234_5678);

      // register 0 is hardwired; no bypass onto it either
      a_wr = 1; a_dst = 5'd0; a_wdata = 32'hFFFF_FFFF;
      tick;
      check("view_reg0_zero", {32'd0, a_view[31:0]}, 64'd0);
      a_wr = 1; a_dst = 5'd0; a_wdata = 32'hFFFF_FFFF;
      a_req = 2'b11; a_addr = {5'd5, 5'd0};
      tick;
      check("rd_reg0_zero", a_rdata, {32'hDEAD_BEEF, 32'd0});

      // scoreboard
      idle; a_rsv = 1; a_rdst = 5'd3;
      tick;
      check("busy_reserve3", {32'd0, a_busy}, 64'h8);
      idle; a_wr = 1; a_dst = 5'd3; a_wdata = 32'h33;
      tick;
      check("busy_clear3", {32'd0, a_busy}, 64'd0);
      idle; a_wr = 1; a_dst = 5'd3; a_wdata = 32'h44; a_rsv = 1; a_rdst = 5'd3;
      tick;
      check("busy_collide3", {32'd0, a_busy}, 64'h8);
      check("view_collide3", {32'd0, a_view[3*32 +: 32]}, 64'h44);
      idle; a_rsv = 1; a_rdst = 5'd0;
      tick;
      check("busy_reserve0", {32'd0, a_busy}, 64'h8);
      idle; a_wr = 1; a_dst = 5'd3; a_wdata = 32'h55; a_rsv = 1; a_rdst = 5'd9;
      tick;
      check("busy_split", {32'd0, a_busy}, 64'h200);

      // second configuration: register 0 is ordinary storage
      idle; b_wr = 1; b_dst = 3'd0; b_wdata = 16'hA5A5;
      tick;
      check("b_view_reg0", {48'd0, b_view[15:0]}, 64'hA5A5);
      idle; b_req = 3'b111; b_addr = {3'd0, 3'd0, 3'd0};
      tick;
      check("b_rd_valid", {61'd0, b_rvld}, 64'd7);
      check("b_rd_data",  {16'd0, b_rdata}, 64'hA5A5_A5A5_A5A5);
      idle; b_rsv = 1; b_rdst = 3'd0;
      tick;
      check("b_busy0", {56'd0, b_busy}, 64'd1);
      idle; b_wr = 1; b_dst = 3'd0; b_wdata = 16'h5A5A; b_req = 3'b100; b_addr = {3'd0, 3'd6, 3'd6};
      tick;
      check("b_bypass0", {16'd0, b_rdata}, 64'h5A5A_A5A5_A5A5);
      check("b_busy_clr", {56'd0, b_busy}, 64'd0);

      // reset while reads are requested
      idle; rst = 1; a_req = 2'b11; a_addr = {5'd5, 5'd7}; b_req = 3'b111;
      tick;
      check("midrst_valid_a", {62'd0, a_rvld}, 64'd0);
      check("midrst_rdata_a", a_rdata, 64'd0);
      check("midrst_view_a",  {63'd0, |a_view}, 64'd0);
      check("midrst_busy_a",  {32'd0, a_busy}, 64'd0);
      check("midrst_valid_b", {61'd0, b_rvld}, 64'd0);
      check("midrst_view_b",  {63'd0, |b_view}, 64'd0);
      rst = 0; idle;
      tick;
      check("postrst_valid_a", {62'd0, a_rvld}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
